// File: rtl/rc4_stream_ctrl_if.sv
// Bus bundle between rc4_stream_ctrl, its job requester, the RC4 core and the byte consumer.
// RC4_XOR_EN adds the plaintext input pt_data.
interface rc4_stream_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] drop_len;
  logic [CNT_W-1:0] ks_len;
  logic             busy;
  logic             done;
  logic             core_start;
  logic             core_key_valid;
  logic [7:0]       core_dout;
  logic             core_nxt_key;
  logic             ks_valid;
  logic             ks_ready;
  logic [7:0]       ks_data;
  logic             ks_last;
`ifdef RC4_XOR_EN
  logic [7:0]       pt_data;

  modport slave (
    input  start, abort, drop_len, ks_len, core_key_valid, core_dout, ks_ready, pt_data,
    output busy, done, core_start, core_nxt_key, ks_valid, ks_data, ks_last
  );
  modport master (
    output start, abort, drop_len, ks_len, core_key_valid, core_dout, ks_ready, pt_data,
    input  busy, done, core_start, core_nxt_key, ks_valid, ks_data, ks_last
  );
`else
  modport slave (
    input  start, abort, drop_len, ks_len, core_key_valid, core_dout, ks_ready,
    output busy, done, core_start, core_nxt_key, ks_valid, ks_data, ks_last
  );
  modport master (
    output start, abort, drop_len, ks_len, core_key_valid, core_dout, ks_ready,
    input  busy, done, core_start, core_nxt_key, ks_valid, ks_data, ks_last
  );
`endif
endinterface

// File: rtl/rc4_stream_ctrl.sv
// RC4 keystream sequencer: kick core, drop N bytes, buffer LEN bytes into a valid/ready stream.
// Optional RC4_XOR_EN: ks_data = head byte XOR pt_data.
//
// state    | meaning
// S_IDLE   | waiting for start
// S_KICK   | one-cycle core_start pulse
// S_DROP   | consuming and discarding drop_len bytes
// S_STREAM | consuming ks_len bytes into the FIFO
// S_DRAIN  | all bytes consumed, waiting for FIFO empty
// S_FIN    | one-cycle done pulse
module rc4_stream_ctrl #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input logic               clk,
  input logic               rst_n,
  rc4_stream_ctrl_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] L_FULL = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_KICK, S_DROP, S_STREAM, S_DRAIN, S_FIN
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_drop_cnt, r_rem_cnt;
  logic             r_guard;
  logic [7:0]       r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_last;
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_eligible, w_consume, w_push, w_pop, w_flush, w_start_acc;
  logic w_valid;
  logic [7:0] w_head;

  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid & bus.ks_ready;
  assign w_flush     = bus.abort & (r_state != S_IDLE);
  assign w_start_acc = bus.start & ~bus.abort & (r_state == S_IDLE);
  assign w_consume   = bus.core_key_valid & ~r_guard & w_eligible & ~bus.abort;
  assign w_push      = w_consume & (r_state == S_STREAM);

  always_comb begin
    w_state_nxt = r_state;
    w_eligible  = 1'b0;
    case (r_state)
      S_IDLE: if (w_start_acc) w_state_nxt = S_KICK;
      S_KICK: begin
        if (r_drop_cnt != '0)     w_state_nxt = S_DROP;
        else if (r_rem_cnt != '0) w_state_nxt = S_STREAM;
        else                      w_state_nxt = S_FIN;
      end
      S_DROP: begin
        w_eligible = 1'b1;
        if (w_consume && r_drop_cnt == CNT_W'(1))
          w_state_nxt = (r_rem_cnt != '0) ? S_STREAM : S_FIN;
      end
      S_STREAM: begin
        // registered occupancy only: a same-cycle pop does not open a slot
        w_eligible = (r_count < L_FULL);
        if (w_consume && r_rem_cnt == CNT_W'(1)) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: if (!w_valid) w_state_nxt = S_FIN;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_flush) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_guard    <= 1'b0;
      r_drop_cnt <= '0;
      r_rem_cnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_guard <= w_consume;
      if (w_start_acc) begin
        r_drop_cnt <= bus.drop_len;
        r_rem_cnt  <= bus.ks_len;
      end else if (w_consume) begin
        if (r_state == S_DROP && r_drop_cnt != '0)  r_drop_cnt <= r_drop_cnt - CNT_W'(1);
        if (r_state == S_STREAM && r_rem_cnt != '0) r_rem_cnt  <= r_rem_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // storage needs no reset: the head is masked whenever the FIFO is empty
  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_fifo_data[r_wr_ptr] <= bus.core_dout;
      r_fifo_last[r_wr_ptr] <= (r_rem_cnt == CNT_W'(1));
    end
  end

  assign w_head = w_valid ? r_fifo_data[r_rd_ptr] : 8'h00;

  assign bus.busy         = (r_state != S_IDLE) && (r_state != S_FIN);
  assign bus.done         = (r_state == S_FIN);
  assign bus.core_start   = (r_state == S_KICK);
  assign bus.core_nxt_key = w_consume;
  assign bus.ks_valid     = w_valid;
  assign bus.ks_last      = w_valid & r_fifo_last[r_rd_ptr];
`ifdef RC4_XOR_EN
  assign bus.ks_data      = w_head ^ bus.pt_data;
`else
  assign bus.ks_data      = w_head;
`endif

endmodule

// File: tb/tb_rc4_stream_ctrl.sv
// Scoreboard bench for rc4_stream_ctrl with a behavioural pipelined RC4 core model.
module tb_rc4_stream_ctrl;

  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rc4_stream_ctrl_if #(.CNT_W(CNT_W)) bus ();

  rc4_stream_ctrl #(.FIFO_DEPTH(4), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int n_nxt = 0, n_kick = 0, n_done = 0, n_pop = 0, n_vld = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // core model: byte = base + index; valid drops for one cycle after each consume
  logic [7:0] core_base = 8'h00;
  int   idx = 0;
  logic s_nxt = 1'b0, s_start = 1'b0, cwait = 1'b0;

  always @(negedge clk) begin
    s_nxt   = bus.core_nxt_key;
    s_start = bus.core_start;
    if (bus.core_nxt_key) n_nxt++;
    if (bus.core_start)   n_kick++;
    if (bus.done)         n_done++;
    if (bus.ks_valid)     n_vld++;
  end

  always @(posedge clk) begin
    #1;
    if (s_start) begin
      idx = 0; bus.core_key_valid = 1'b0; cwait = 1'b1;
    end else if (s_nxt) begin
      idx++; bus.core_key_valid = 1'b0; cwait = 1'b1;
    end else if (cwait) begin
      bus.core_key_valid = 1'b1; cwait = 1'b0;
    end
    bus.core_dout = core_base + idx[7:0];
  end

  // monitor: compare every accepted stream byte against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (bus.ks_valid && bus.ks_ready) begin
      n_pop++;
      if (sb.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_byte: got %0h want none", bus.ks_data);
      end else begin
        e = sb.pop_front();
        chk("ks_data", bus.ks_data, e.d);
        chk("ks_last", bus.ks_last, e.l);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int d, input int l, input logic [7:0] base);
    exp_t e;
    bus.drop_len = CNT_W'(d);
    bus.ks_len   = CNT_W'(l);
    core_base    = base;
    for (int i = 0; i < l; i++) begin
      e.d = base + 8'(d + i);
      e.l = (i == l - 1);
      sb.push_back(e);
    end
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    logic seen = 1'b0;
    while (!seen && k < budget) begin
      @(negedge clk);
      k++;
      if (bus.done) begin
        seen = 1'b1;
        chk({name, "_busy_at_done"}, bus.busy, 0);
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL %s_timeout: got no done want done within %0d cycles", name, budget);
    end
    @(posedge clk);
    #1;
  endtask

  int b_nxt, b_kick, b_done, b_pop, b_vld, seen;

  initial begin
    bus.start = 0; bus.abort = 0; bus.drop_len = '0; bus.ks_len = '0;
    bus.ks_ready = 0; bus.core_key_valid = 0; bus.core_dout = '0;
`ifdef RC4_XOR_EN
    bus.pt_data = 8'h00;
`endif
    #12;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_nxt_key", bus.core_nxt_key, 0);
    chk("rst_ks_valid", bus.ks_valid, 0);
    chk("rst_ks_last", bus.ks_last, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(2);

    // basic
    bus.ks_ready = 1;
    b_nxt = n_nxt; b_kick = n_kick; b_done = n_done; b_pop = n_pop;
    start_job(0, 5, 8'h11);
    chk("basic_core_start_lat", bus.core_start, 1);
    chk("basic_busy", bus.busy, 1);
    wait_done(100, "basic");
    cyc(1);
    chk("basic_kicks", n_kick - b_kick, 1);
    chk("basic_nxt", n_nxt - b_nxt, 5);
    chk("basic_done", n_done - b_done, 1);
    chk("basic_pops", n_pop - b_pop, 5);
    chk("basic_sb_empty", sb.size(), 0);

    // drop
    b_nxt = n_nxt; b_pop = n_pop;
    start_job(3, 2, 8'hA0);
    wait_done(100, "drop");
    cyc(1);
    chk("drop_nxt", n_nxt - b_nxt, 5);
    chk("drop_pops", n_pop - b_pop, 2);
    chk("drop_sb_empty", sb.size(), 0);

    // backpressure
    bus.ks_ready = 0;
    b_nxt = n_nxt; b_pop = n_pop;
    start_job(0, 10, 8'h30);
    cyc(40);
    chk("bp_nxt_stall", n_nxt - b_nxt, 4);
    chk("bp_valid", bus.ks_valid, 1);
    chk("bp_head", bus.ks_data, 8'h30);
    bus.ks_ready = 1;
    wait_done(200, "bp");
    cyc(1);
    chk("bp_nxt_total", n_nxt - b_nxt, 10);
    chk("bp_pops", n_pop - b_pop, 10);
    chk("bp_sb_empty", sb.size(), 0);

    // zero length with a start issued while busy
    b_nxt = n_nxt; b_kick = n_kick; b_done = n_done; b_vld = n_vld;
    start_job(2, 0, 8'h50);
    bus.drop_len = 16'd7; bus.ks_len = 16'd9; bus.start = 1;
    cyc(1);
    bus.start = 0;
    wait_done(100, "zero");
    cyc(3);
    chk("zero_kicks", n_kick - b_kick, 1);
    chk("zero_nxt", n_nxt - b_nxt, 2);
    chk("zero_valid_cycles", n_vld - b_vld, 0);
    chk("zero_done_cycles", n_done - b_done, 1);
    chk("zero_idle_busy", bus.busy, 0);

    // abort after 3 bytes delivered
    bus.ks_ready = 1;
    b_pop = n_pop; b_done = n_done;
    start_job(0, 8, 8'h70);
    seen = 0;
    for (int k = 0; k < 200 && seen < 3; k++) begin
      @(negedge clk);
      if (bus.ks_valid && bus.ks_ready) seen++;
    end
    chk("abort_reached_3", seen, 3);
    @(posedge clk); #1;
    bus.ks_ready = 0;
    bus.abort = 1;
    b_nxt = n_nxt;
    cyc(1);
    bus.abort = 0;
    chk("abort_valid", bus.ks_valid, 0);
    chk("abort_busy", bus.busy, 0);
    sb.delete();
    bus.ks_ready = 1;
    cyc(10);
    chk("abort_no_nxt", n_nxt - b_nxt, 0);
    chk("abort_no_done", n_done - b_done, 0);
    chk("abort_pops", n_pop - b_pop, 3);
    b_pop = n_pop; b_done = n_done;
    start_job(1, 3, 8'h90);
    wait_done(100, "post_abort");
    cyc(1);
    chk("post_abort_pops", n_pop - b_pop, 3);
    chk("post_abort_done", n_done - b_done, 1);
    chk("post_abort_sb_empty", sb.size(), 0);

    // asynchronous reset mid-stream
    bus.ks_ready = 0;
    start_job(0, 10, 8'hC0);
    cyc(20);
    chk("rst_mid_busy_before", bus.busy, 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_valid", bus.ks_valid, 0);
    chk("rst_mid_nxt", bus.core_nxt_key, 0);
    chk("rst_mid_core_start", bus.core_start, 0);
    chk("rst_mid_last", bus.ks_last, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    bus.ks_ready = 1;
    cyc(3);
    chk("rst_rel_valid", bus.ks_valid, 0);
    chk("rst_rel_busy", bus.busy, 0);
    b_pop = n_pop;
    start_job(0, 2, 8'hE0);
    wait_done(100, "post_rst");
    cyc(1);
    chk("post_rst_pops", n_pop - b_pop, 2);
    chk("post_rst_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1, "timeout");
  end

endmodule
